// File: rtl/cm_ucie_d2d_alsm_bringup_seq.sv
// ---------------------------------------------------------------------------
// cm_ucie_d2d_alsm_bringup_seq
//
// Adapter bringup sequencer for the UCIe D2D RX adapter link state machine.
// A rising edge on bringup_start_i (with RDI ACTIVE) runs a two-phase
// sideband exchange with the remote die:
//   1. ADV_CAP request, wait for the ADV_CAP response
//   2. ACTIVE_REQ request, wait for the ACTIVE_RSP response
// Each phase is re-sent on timeout up to MAX_RETRY times. Success gives a
// one-cycle bringup_done_o pulse; running out of retries parks the FSM in
// ERROR with bringup_err_o high until the next start edge.
//
// Sideband request handshake: sb_req_vld_o is raised in a SEND state and
// holds, together with sb_req_msg_o, until a cycle where sb_req_rdy_i is
// also high; that cycle is the transfer. vld may drop without a transfer
// only when RDI leaves ACTIVE (abort) or on reset. Responses are single
// cycle pulses on sb_rsp_vld_i; they are only consumed in a WAIT state.
//
// Ports
//   clk_i            clock
//   rstn_i           synchronous active-low reset
//   swrst_i          synchronous active-high soft reset (same effect)
//   rdi_state_sts_i  RDI state, 4'b0001 = ACTIVE
//   bringup_start_i  bringup request from the ALSM core (edge triggered)
//   bringup_done_o   single-cycle success pulse
//   bringup_err_o    error flag, high while in ERROR
//   sb_req_vld_o     sideband request valid
//   sb_req_rdy_i     sideband request ready
//   sb_req_msg_o     2'b00 ADV_CAP, 2'b01 ACTIVE_REQ
//   sb_rsp_vld_i     sideband response valid
//   sb_rsp_msg_i     2'b00 ADV_CAP, 2'b01 ACTIVE_RSP
//   state_o          current FSM state (debug)
// ---------------------------------------------------------------------------
module cm_ucie_d2d_alsm_bringup_seq #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       swrst_i,
  input  logic [3:0] rdi_state_sts_i,
  input  logic       bringup_start_i,
  output logic       bringup_done_o,
  output logic       bringup_err_o,
  output logic       sb_req_vld_o,
  input  logic       sb_req_rdy_i,
  output logic [1:0] sb_req_msg_o,
  input  logic       sb_rsp_vld_i,
  input  logic [1:0] sb_rsp_msg_i,
  output logic [2:0] state_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [3:0] RDI_ACTIVE = 4'b0001;
  localparam logic [1:0] MSG_CAP    = 2'b00;
  localparam logic [1:0] MSG_ACT    = 2'b01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_CAP = 3'd1,
    WAIT_CAP = 3'd2,
    SEND_ACT = 3'd3,
    WAIT_ACT = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t          state_q;
  logic            start_q;
  logic [TW-1:0]   timer_q;
  logic [RW-1:0]   retry_q;

  logic            start_evt;
  logic            rdi_active;
  logic [1:0]      exp_rsp_msg;
  logic            rsp_hit;

  // start_q resets to 0 so a start held high through reset still counts
  // as an edge on the first cycle out of reset.
  assign start_evt   = bringup_start_i & ~start_q;
  assign rdi_active  = (rdi_state_sts_i == RDI_ACTIVE);
  assign exp_rsp_msg = (state_q == WAIT_ACT) ? MSG_ACT : MSG_CAP;
  assign rsp_hit     = sb_rsp_vld_i && (sb_rsp_msg_i == exp_rsp_msg);

  always_ff @(posedge clk_i) begin
    if (!rstn_i || swrst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      start_q <= bringup_start_i;
      case (state_q)
        IDLE, ERROR: begin
          if (start_evt && rdi_active) begin
            state_q <= SEND_CAP;
            retry_q <= '0;
          end
        end
        SEND_CAP, SEND_ACT: begin
          // Abort wins over the handshake: vld drops even if rdy is high.
          if (!rdi_active) begin
            state_q <= IDLE;
          end else if (sb_req_rdy_i) begin
            state_q <= (state_q == SEND_CAP) ? WAIT_CAP : WAIT_ACT;
            timer_q <= '0;
          end
        end
        WAIT_CAP, WAIT_ACT: begin
          // Order encodes priority: abort, then response, then timeout.
          // A response on the timeout cycle is therefore accepted.
          if (!rdi_active) begin
            state_q <= IDLE;
          end else if (rsp_hit) begin
            state_q <= (state_q == WAIT_CAP) ? SEND_ACT : DONE;
            retry_q <= '0;
          end else if (timer_q == TIMER_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RW'(1);
              state_q <= (state_q == WAIT_CAP) ? SEND_CAP : SEND_ACT;
            end else begin
              state_q <= ERROR;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Moore decode: every output is a function of the state register only.
  assign sb_req_vld_o   = (state_q == SEND_CAP) || (state_q == SEND_ACT);
  assign sb_req_msg_o   = (state_q == SEND_ACT) ? MSG_ACT : MSG_CAP;
  assign bringup_done_o = (state_q == DONE);
  assign bringup_err_o  = (state_q == ERROR);
  assign state_o        = state_q;

endmodule

// File: tb/tb_cm_ucie_d2d_alsm_bringup_seq.sv
// ---------------------------------------------------------------------------
// Testbench for cm_ucie_d2d_alsm_bringup_seq (TIMEOUT_CYCLES=16, MAX_RETRY=2).
// Each bringup is described by a plan: per phase and per attempt, how many
// cycles the remote holds off ready and after how many WAIT cycles it
// responds (-1 = never). The reference model turns a plan into the expected
// handshake list (message and cycle), the done or error cycle, and the total
// stall count, using the protocol's cycle-accounting rules. A responder task
// plays the remote die from the same plan.
// ---------------------------------------------------------------------------
module tb_cm_ucie_d2d_alsm_bringup_seq;

  localparam int TO = 16;
  localparam int MR = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rstn_i;
  logic       swrst_i;
  logic [3:0] rdi_state_sts_i;
  logic       bringup_start_i;
  logic       bringup_done_o;
  logic       bringup_err_o;
  logic       sb_req_vld_o;
  logic       sb_req_rdy_i;
  logic [1:0] sb_req_msg_o;
  logic       sb_rsp_vld_i;
  logic [1:0] sb_rsp_msg_i;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  cm_ucie_d2d_alsm_bringup_seq #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MR)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .swrst_i        (swrst_i),
    .rdi_state_sts_i(rdi_state_sts_i),
    .bringup_start_i(bringup_start_i),
    .bringup_done_o (bringup_done_o),
    .bringup_err_o  (bringup_err_o),
    .sb_req_vld_o   (sb_req_vld_o),
    .sb_req_rdy_i   (sb_req_rdy_i),
    .sb_req_msg_o   (sb_req_msg_o),
    .sb_rsp_vld_i   (sb_rsp_vld_i),
    .sb_rsp_msg_i   (sb_rsp_msg_i),
    .state_o        (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- plan and scoreboard ----------------
  int p_rdy [2][MR+1];
  int p_rsp [2][MR+1];
  bit p_noise;
  int ab_kind;   // 0 none, 1 RDI drop, 2 swrst pulse
  int ab_off;    // cycle offset (from start) at which the abort is driven

  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_done;
  int         exp_err;
  int         exp_stall;

  logic [1:0] got_q[$];
  int         got_cyc_q[$];

  task automatic plan_random();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a <= MR; a++) begin
        p_rdy[p][a] = $urandom_range(0, 3);
        p_rsp[p][a] = $urandom_range(0, 6);
      end
    end
    p_noise = 1'b0;
    ab_kind = 0;
    ab_off  = 0;
  endtask

  // Reference model. Offsets count cycles after the start-edge sample.
  // A SEND attempt lasts rdy+1 cycles; a WAIT lasts rsp+1 cycles when
  // answered, or TO cycles on timeout. MR+1 unanswered attempts -> ERROR.
  task automatic model_plan();
    int  t;
    bit  failed;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_done  = -1;
    exp_err   = -1;
    exp_stall = 0;
    t         = 1;
    failed    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (!failed) begin
        for (int a = 0; a <= MR; a++) begin
          exp_q.push_back(2'(p));
          exp_cyc_q.push_back(t + p_rdy[p][a]);
          exp_stall += p_rdy[p][a];
          t += p_rdy[p][a] + 1;
          if (p_rsp[p][a] >= 0) begin
            t += p_rsp[p][a] + 1;
            break;
          end
          t += TO;
          if (a == MR) failed = 1'b1;
        end
      end
    end
    if (failed) exp_err = t;
    else        exp_done = t;
    if (ab_kind != 0) begin
      exp_done = -1;
      exp_err  = -1;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= ab_off) begin
        void'(exp_cyc_q.pop_back());
        void'(exp_q.pop_back());
      end
    end
  endtask

  // ---------------- driver / responder ----------------
  task automatic drive_idle();
    bringup_start_i = 1'b0;
    sb_req_rdy_i    = 1'b0;
    sb_rsp_vld_i    = 1'b0;
    sb_rsp_msg_i    = 2'b00;
    swrst_i         = 1'b0;
  endtask

  task automatic run_plan(input string name);
    int c, ph, att, scnt, wcnt, done_n, done_at, err_at, stalls, budget;
    bit in_wait, fin, noise_prev;
    model_plan();
    got_q.delete();
    got_cyc_q.delete();
    ph = 0; att = 0; scnt = 0; wcnt = 0; in_wait = 0; fin = 0; noise_prev = 0;
    done_n = 0; done_at = -1; err_at = -1; stalls = 0;
    budget = (ab_kind != 0) ? ab_off + 4 : ((exp_done >= 0) ? exp_done : exp_err) + 4;

    @(negedge clk);
    bringup_start_i = 1'b1;
    c = cyc;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      drive_idle();
      if (ab_kind == 1 && k == ab_off + 2) rdi_state_sts_i = 4'b0001;
      if (bringup_done_o) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (bringup_err_o && err_at < 0) err_at = k;
      if (noise_prev) begin
        n_checks++;
        if (state_o !== 3'd2) begin
          n_fail++;
          $display("FAIL %s noise_ignored: state %0d exp 2 at +%0d", name, state_o, k);
        end
      end
      noise_prev = 1'b0;
      if (ab_kind != 0 && k == ab_off + 1) begin
        n_checks++;
        if ({state_o, sb_req_vld_o, sb_req_msg_o, bringup_done_o, bringup_err_o} !== 8'b0) begin
          n_fail++;
          $display("FAIL %s abort_outputs: state %0d vld %0b msg %0d done %0b err %0b exp all 0",
                   name, state_o, sb_req_vld_o, sb_req_msg_o, bringup_done_o, bringup_err_o);
        end
      end
      // remote die
      if (!fin && sb_req_vld_o) begin
        if (in_wait) begin
          in_wait = 1'b0;
          if (att < MR) att++;
          scnt = 0;
        end
        if (scnt >= p_rdy[ph][att]) begin
          sb_req_rdy_i = 1'b1;
          got_q.push_back(sb_req_msg_o);
          got_cyc_q.push_back(k);
          in_wait = 1'b1;
          wcnt = 0;
        end else begin
          scnt++;
          if (sb_req_msg_o === 2'(ph)) stalls++;
        end
      end else if (!fin && in_wait) begin
        if (wcnt == p_rsp[ph][att]) begin
          sb_rsp_vld_i = 1'b1;
          sb_rsp_msg_i = 2'(ph);
          in_wait = 1'b0;
          if (ph == 1) fin = 1'b1;
          else begin ph = 1; att = 0; scnt = 0; end
        end else if (p_noise && ph == 0 && wcnt < TO - 1) begin
          sb_rsp_vld_i = 1'b1;
          sb_rsp_msg_i = 2'($urandom_range(1, 3));
          noise_prev = 1'b1;
        end
        wcnt++;
      end
      if (ab_kind == 1 && k == ab_off) rdi_state_sts_i = 4'b0000;
      if (ab_kind == 2 && k == ab_off) swrst_i = 1'b1;
    end

    // scoreboard
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s hs_count: got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      n_checks++;
      if (got_q[0] !== exp_q[0] || got_cyc_q[0] !== exp_cyc_q[0]) begin
        n_fail++;
        $display("FAIL %s hs: got msg %0d @+%0d exp msg %0d @+%0d",
                 name, got_q[0], got_cyc_q[0], exp_q[0], exp_cyc_q[0]);
      end
      void'(got_q.pop_front());   void'(got_cyc_q.pop_front());
      void'(exp_q.pop_front());   void'(exp_cyc_q.pop_front());
    end
    n_checks++;
    if (done_n !== ((exp_done >= 0) ? 1 : 0) || done_at !== exp_done) begin
      n_fail++;
      $display("FAIL %s done: got %0d pulses first @+%0d exp @+%0d", name, done_n, done_at, exp_done);
    end
    n_checks++;
    if (err_at !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_time: got @+%0d exp @+%0d", name, err_at, exp_err);
    end
    n_checks++;
    if (state_o !== ((exp_err >= 0) ? 3'd6 : 3'd0) || bringup_err_o !== (exp_err >= 0)) begin
      n_fail++;
      $display("FAIL %s end_state: state %0d err %0b exp_err_case %0b", name, state_o, bringup_err_o, exp_err >= 0);
    end
    if (ab_kind == 0) begin
      n_checks++;
      if (stalls !== exp_stall) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d exp %0d", name, stalls, exp_stall);
      end
    end
    if (c < 0) $display("unexpected cycle origin");
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn_i = 1'b0;
    drive_idle();
    rdi_state_sts_i = 4'b0001;
    bringup_start_i = 1'b1;   // held through reset: must still trigger
    repeat (3) @(negedge clk);
    n_checks++;
    if ({state_o, sb_req_vld_o, sb_req_msg_o, bringup_done_o, bringup_err_o} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_values: state %0d vld %0b msg %0d done %0b err %0b exp all 0",
               state_o, sb_req_vld_o, sb_req_msg_o, bringup_done_o, bringup_err_o);
    end
    rstn_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd1 || sb_req_vld_o !== 1'b1) begin
      n_fail++;
      $display("FAIL start_held_from_reset: state %0d vld %0b exp 1 1", state_o, sb_req_vld_o);
    end
    rdi_state_sts_i = 4'b0000;
    @(negedge clk);
    bringup_start_i = 1'b0;
    rdi_state_sts_i = 4'b0001;
    n_checks++;
    if (state_o !== 3'd0 || sb_req_vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_send: state %0d vld %0b exp 0 0", state_o, sb_req_vld_o);
    end
  endtask

  task automatic test_start_rdi_inactive();
    @(negedge clk);
    rdi_state_sts_i = 4'b0000;
    bringup_start_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (state_o !== 3'd0) begin
        n_fail++;
        $display("FAIL start_dropped: state %0d exp 0", state_o);
      end
    end
    bringup_start_i = 1'b0;
    rdi_state_sts_i = 4'b0001;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    plan_random();
    for (int p = 0; p < 2; p++) begin p_rdy[p][0] = 0; p_rsp[p][0] = 3; end
    run_plan("nominal");
    plan_random();
    for (int p = 0; p < 2; p++) begin p_rdy[p][0] = 0; p_rsp[p][0] = 0; end
    run_plan("best_case");
    for (int i = 0; i < 4; i++) begin
      plan_random();
      run_plan("nominal_rand");
    end
  endtask

  task automatic test_backpressure();
    plan_random();
    p_rdy[0][0] = 7;
    run_plan("backpressure");
  endtask

  task automatic test_single_timeout();
    plan_random();
    p_rsp[0][0] = -1;
    run_plan("single_timeout");
    plan_random();
    p_rsp[1][0] = -1;
    p_rsp[1][1] = -1;
    run_plan("two_timeouts_act");
  endtask

  task automatic test_timeout_cycle_rsp();
    plan_random();
    p_rsp[0][0] = TO - 1;
    run_plan("rsp_on_timeout_cycle");
  endtask

  task automatic test_exhausted();
    plan_random();
    for (int a = 0; a <= MR; a++) p_rsp[1][a] = -1;
    run_plan("exhausted_retries");
    plan_random();
    run_plan("restart_from_error");
  endtask

  task automatic test_wrong_msg();
    plan_random();
    p_noise = 1'b1;
    p_rsp[0][0] = $urandom_range(3, 8);
    run_plan("wrong_msg");
  endtask

  task automatic test_abort();
    int t_act;
    plan_random();
    p_rsp[1][0] = -1;
    t_act   = 1 + p_rdy[0][0] + 1 + p_rsp[0][0] + 1;
    ab_kind = 1;
    ab_off  = t_act + p_rdy[1][0] + 1 + $urandom_range(0, 10);
    run_plan("abort_wait_act");
    @(negedge clk);
    sb_rsp_vld_i = 1'b1;
    sb_rsp_msg_i = 2'b01;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (state_o !== 3'd0 || bringup_done_o !== 1'b0 || bringup_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rsp_ignored: state %0d done %0b err %0b exp 0 0 0",
               state_o, bringup_done_o, bringup_err_o);
    end
  endtask

  task automatic test_swrst();
    int t_act;
    plan_random();
    p_rdy[1][0] = 6;
    t_act   = 1 + p_rdy[0][0] + 1 + p_rsp[0][0] + 1;
    ab_kind = 2;
    ab_off  = t_act + $urandom_range(0, 2);
    run_plan("swrst_send_act");
  endtask

  initial begin
    drive_idle();
    rstn_i = 1'b0;
    rdi_state_sts_i = 4'b0001;
    test_reset();
    test_start_rdi_inactive();
    test_nominal();
    test_backpressure();
    test_single_timeout();
    test_timeout_cycle_rsp();
    test_exhausted();
    test_wrong_msg();
    test_abort();
    test_swrst();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
